instr_fetch_unit: RTL and testbench

- Downstream consumer of the fetch trigger sequencer's one-cycle trigger pulses.
- Owns the program counter and drives the program-memory address, muxing between PC and PC+1.
- Captures the two instruction words and presents opcode/operand to execute.
- Checks the trigger order with an internal FSM and flags any protocol violation.

---
 rtl/instr_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Program counter, program-memory address mux, and two-word instruction capture, driven by one-cycle trigger pulses.
// Latency: opcode 1 cycle after decode1, operand/instr_valid 1 cycle after decode2; no backpressure (pulses always accepted).
// Optional INSTR_FETCH_JUMP_EN: update_pc in S_DONE with jump_req loads jump_target instead of pc+2.
module instr_fetch_unit #(
    parameter int               ADDR_W   = 8,
    parameter int               DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              update_pc_trigger,
    input  logic              fetch_prog_mem1_trigger,
    input  logic              fetch_prog_mem2_trigger,
    input  logic              decode_instr1_trigger,
    input  logic              decode_instr2_trigger,
    input  logic              mem_mux_control,
    input  logic [DATA_W-1:0] prog_mem_data,
    input  logic              jump_req,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] prog_mem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] opcode,
    output logic [DATA_W-1:0] operand,
    output logic              instr_valid,
    output logic              seq_error
);

    typedef enum logic [2:0] {
        S_START,
        S_WAIT_F1,
        S_WAIT_D1,
        S_WAIT_F2,
        S_WAIT_D2,
        S_DONE
    } state_t;

    // Trigger bit order: {update, fetch1, decode1, fetch2, decode2}
    localparam logic [4:0] T_UPD = 5'b10000;
    localparam logic [4:0] T_F1  = 5'b01000;
    localparam logic [4:0] T_D1  = 5'b00100;
    localparam logic [4:0] T_F2  = 5'b00010;
    localparam logic [4:0] T_D2  = 5'b00001;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] word1_q;
    logic [DATA_W-1:0] word2_q;
    logic [DATA_W-1:0] opcode_q;
    logic [DATA_W-1:0] operand_q;
    logic              instr_valid_q;
    logic              seq_error_q;

    logic [4:0]        trig;
    logic [4:0]        trig_exp;
    logic              trig_any;
    logic              trig_err;
    logic [ADDR_W-1:0] pc_next_d;

    assign trig = {update_pc_trigger, fetch_prog_mem1_trigger, decode_instr1_trigger,
                   fetch_prog_mem2_trigger, decode_instr2_trigger};

    always_comb begin
        trig_exp = T_UPD;
        case (state_q)
            S_START:   trig_exp = T_UPD;
            S_WAIT_F1: trig_exp = T_F1;
            S_WAIT_D1: trig_exp = T_D1;
            S_WAIT_F2: trig_exp = T_F2;
            S_WAIT_D2: trig_exp = T_D2;
            S_DONE:    trig_exp = T_UPD;
            default:   trig_exp = T_UPD;
        endcase
    end

    // Expected vector is one-hot, so any mismatch also catches multiple triggers at once
    assign trig_any = |trig;
    assign trig_err = trig_any && (trig != trig_exp);

`ifdef INSTR_FETCH_JUMP_EN
    assign pc_next_d = jump_req ? jump_target : pc_q + ADDR_W'(2);
`else
    logic unused_jump;
    assign unused_jump = &{1'b0, jump_req, jump_target};
    assign pc_next_d   = pc_q + ADDR_W'(2);
`endif

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            state_q       <= S_START;
            pc_q          <= RESET_PC;
            word1_q       <= '0;
            word2_q       <= '0;
            opcode_q      <= '0;
            operand_q     <= '0;
            instr_valid_q <= 1'b0;
            seq_error_q   <= 1'b0;
        end else if (trig_err) begin
            state_q       <= S_START;
            instr_valid_q <= 1'b0;
            seq_error_q   <= 1'b1;
        end else if (trig_any) begin
            case (state_q)
                S_START: begin
                    state_q <= S_WAIT_F1;
                end
                S_WAIT_F1: begin
                    word1_q <= prog_mem_data;
                    state_q <= S_WAIT_D1;
                end
                S_WAIT_D1: begin
                    opcode_q <= word1_q;
                    state_q  <= S_WAIT_F2;
                end
                S_WAIT_F2: begin
                    word2_q <= prog_mem_data;
                    state_q <= S_WAIT_D2;
                end
                S_WAIT_D2: begin
                    operand_q     <= word2_q;
                    instr_valid_q <= 1'b1;
                    state_q       <= S_DONE;
                end
                S_DONE: begin
                    pc_q          <= pc_next_d;
                    instr_valid_q <= 1'b0;
                    state_q       <= S_WAIT_F1;
                end
                default: begin
                    state_q <= S_START;
                end
            endcase
        end
    end

    assign prog_mem_addr = mem_mux_control ? pc_q + ADDR_W'(1) : pc_q;
    assign pc            = pc_q;
    assign opcode        = opcode_q;
    assign operand       = operand_q;
    assign instr_valid   = instr_valid_q;
    assign seq_error     = seq_error_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: three instances with RESET_PC 0x00, 0xFE and 0xFF share the trigger inputs.
module tb_instr_fetch_unit;

    localparam logic [4:0] T_NONE = 5'b00000;
    localparam logic [4:0] T_UPD  = 5'b10000;
    localparam logic [4:0] T_F1   = 5'b01000;
    localparam logic [4:0] T_D1   = 5'b00100;
    localparam logic [4:0] T_F2   = 5'b00010;
    localparam logic [4:0] T_D2   = 5'b00001;

    logic       clock;
    logic       n_reset;
    logic       upd, f1, d1, f2, d2;
    logic       mux;
    logic       jump_req;
    logic [7:0] jump_target;
    logic [7:0] mem [256];

    logic [7:0] addr [3];
    logic [7:0] data [3];
    logic [7:0] pcv  [3];
    logic [7:0] opc  [3];
    logic [7:0] opr  [3];
    logic       vld  [3];
    logic       err  [3];

    logic [7:0] last_addr [3];
    logic [7:0] f1a [3];
    logic [7:0] f2a [3];
    logic [7:0] exp_pc;
    logic [7:0] exp_a1;
    logic [7:0] exp_op;

    int checks;
    int failures;

    assign data[0] = mem[addr[0]];
    assign data[1] = mem[addr[1]];
    assign data[2] = mem[addr[2]];

    instr_fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
        .clock(clock), .n_reset(n_reset),
        .update_pc_trigger(upd), .fetch_prog_mem1_trigger(f1), .fetch_prog_mem2_trigger(f2),
        .decode_instr1_trigger(d1), .decode_instr2_trigger(d2), .mem_mux_control(mux),
        .prog_mem_data(data[0]), .jump_req(jump_req), .jump_target(jump_target),
        .prog_mem_addr(addr[0]), .pc(pcv[0]), .opcode(opc[0]), .operand(opr[0]),
        .instr_valid(vld[0]), .seq_error(err[0])
    );

    instr_fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'hFE)) dut_fe (
        .clock(clock), .n_reset(n_reset),
        .update_pc_trigger(upd), .fetch_prog_mem1_trigger(f1), .fetch_prog_mem2_trigger(f2),
        .decode_instr1_trigger(d1), .decode_instr2_trigger(d2), .mem_mux_control(mux),
        .prog_mem_data(data[1]), .jump_req(jump_req), .jump_target(jump_target),
        .prog_mem_addr(addr[1]), .pc(pcv[1]), .opcode(opc[1]), .operand(opr[1]),
        .instr_valid(vld[1]), .seq_error(err[1])
    );

    instr_fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'hFF)) dut_ff (
        .clock(clock), .n_reset(n_reset),
        .update_pc_trigger(upd), .fetch_prog_mem1_trigger(f1), .fetch_prog_mem2_trigger(f2),
        .decode_instr1_trigger(d1), .decode_instr2_trigger(d2), .mem_mux_control(mux),
        .prog_mem_data(data[2]), .jump_req(jump_req), .jump_target(jump_target),
        .prog_mem_addr(addr[2]), .pc(pcv[2]), .opcode(opc[2]), .operand(opr[2]),
        .instr_valid(vld[2]), .seq_error(err[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive on the falling edge, note the address just before the rising edge, release #1 after it
    task automatic step(input logic [4:0] t, input logic m);
        @(negedge clock);
        {upd, f1, d1, f2, d2} = t;
        mux = m;
        #1;
        for (int k = 0; k < 3; k++) last_addr[k] = addr[k];
        @(posedge clock);
        #1;
        {upd, f1, d1, f2, d2} = T_NONE;
    endtask

    task automatic do_reset();
        @(negedge clock);
        n_reset = 1'b0;
        {upd, f1, d1, f2, d2} = T_NONE;
        @(posedge clock);
        #1;
        n_reset = 1'b1;
    endtask

    task automatic run_instr();
        step(T_UPD, 1'b0);
        step(T_F1, 1'b0);
        for (int k = 0; k < 3; k++) f1a[k] = last_addr[k];
        step(T_D1, 1'b0);
        step(T_F2, 1'b1);
        for (int k = 0; k < 3; k++) f2a[k] = last_addr[k];
        step(T_D2, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        mux = 1'b0;
        #1;
        checks++; if (pcv[0] !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h exp=00", pcv[0]); end
        checks++; if (opc[0] !== 8'h00 || opr[0] !== 8'h00) begin failures++; $display("FAIL reset_words got=%h/%h exp=00/00", opc[0], opr[0]); end
        checks++; if (vld[0] !== 1'b0 || err[0] !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b/%b exp=0/0", vld[0], err[0]); end
        checks++; if (pcv[1] !== 8'hFE) begin failures++; $display("FAIL reset_pc_fe got=%h exp=fe", pcv[1]); end
        mux = 1'b1;
        #1;
        checks++; if (addr[0] !== 8'h01) begin failures++; $display("FAIL addr_mux1 got=%h exp=01", addr[0]); end
        checks++; if (addr[2] !== 8'h00) begin failures++; $display("FAIL addr_wrap_ff got=%h exp=00", addr[2]); end
        mux = 1'b0;
    endtask

    task automatic test_first_instr();
        do_reset();
        step(T_UPD, 1'b0);
        step(T_F1, 1'b0);
        checks++; if (last_addr[0] !== 8'h00) begin failures++; $display("FAIL first_a1 got=%h exp=00", last_addr[0]); end
        step(T_D1, 1'b0);
        checks++; if (opc[0] !== 8'h3A || vld[0] !== 1'b0) begin failures++; $display("FAIL first_opcode got=%h v=%b exp=3a v=0", opc[0], vld[0]); end
        step(T_F2, 1'b1);
        checks++; if (last_addr[0] !== 8'h01) begin failures++; $display("FAIL first_a2 got=%h exp=01", last_addr[0]); end
        checks++; if (opr[0] !== 8'h00 || vld[0] !== 1'b0) begin failures++; $display("FAIL first_pre_d2 got=%h v=%b exp=00 v=0", opr[0], vld[0]); end
        step(T_D2, 1'b1);
        checks++; if (opr[0] !== 8'h7F || vld[0] !== 1'b1 || pcv[0] !== 8'h00) begin failures++; $display("FAIL first_done got=%h v=%b pc=%h exp=7f v=1 pc=00", opr[0], vld[0], pcv[0]); end
    endtask

    task automatic test_second_instr();
        step(T_NONE, 1'b0);
        step(T_NONE, 1'b1);
        checks++; if (vld[0] !== 1'b1 || pcv[0] !== 8'h00 || opc[0] !== 8'h3A) begin failures++; $display("FAIL hold got=v%b pc=%h op=%h exp=v1 pc=00 op=3a", vld[0], pcv[0], opc[0]); end
        step(T_UPD, 1'b0);
        checks++; if (pcv[0] !== 8'h02 || vld[0] !== 1'b0) begin failures++; $display("FAIL second_upd got=pc%h v%b exp=pc02 v0", pcv[0], vld[0]); end
        step(T_F1, 1'b0);
        for (int k = 0; k < 3; k++) f1a[k] = last_addr[k];
        step(T_D1, 1'b0);
        step(T_F2, 1'b1);
        for (int k = 0; k < 3; k++) f2a[k] = last_addr[k];
        step(T_D2, 1'b1);
        checks++; if (f1a[0] !== 8'h02 || f2a[0] !== 8'h03) begin failures++; $display("FAIL second_addr got=%h/%h exp=02/03", f1a[0], f2a[0]); end
        checks++; if (opc[0] !== 8'h11 || opr[0] !== 8'h22 || vld[0] !== 1'b1) begin failures++; $display("FAIL second_instr got=%h/%h v%b exp=11/22 v1", opc[0], opr[0], vld[0]); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        run_instr();
        checks++; if (f1a[1] !== 8'hFE || f2a[1] !== 8'hFF) begin failures++; $display("FAIL wrap_addr1 got=%h/%h exp=fe/ff", f1a[1], f2a[1]); end
        checks++; if (opc[1] !== 8'hA1 || opr[1] !== 8'hB2) begin failures++; $display("FAIL wrap_instr1 got=%h/%h exp=a1/b2", opc[1], opr[1]); end
        run_instr();
        checks++; if (pcv[1] !== 8'h00) begin failures++; $display("FAIL wrap_pc got=%h exp=00", pcv[1]); end
        checks++; if (f1a[1] !== 8'h00 || f2a[1] !== 8'h01) begin failures++; $display("FAIL wrap_addr2 got=%h/%h exp=00/01", f1a[1], f2a[1]); end
        checks++; if (opc[1] !== 8'h3A || opr[1] !== 8'h7F || vld[1] !== 1'b1) begin failures++; $display("FAIL wrap_instr2 got=%h/%h v%b exp=3a/7f v1", opc[1], opr[1], vld[1]); end
    endtask

    task automatic test_wrong_order();
        do_reset();
        run_instr();
        step(T_UPD, 1'b0);
        step(T_D1, 1'b0);
        checks++; if (err[0] !== 1'b1 || vld[0] !== 1'b0 || pcv[0] !== 8'h02) begin failures++; $display("FAIL order_err got=e%b v%b pc=%h exp=e1 v0 pc=02", err[0], vld[0], pcv[0]); end
        checks++; if (opc[0] !== 8'h3A) begin failures++; $display("FAIL order_nocapture got=%h exp=3a", opc[0]); end
        run_instr();
        checks++; if (pcv[0] !== 8'h02 || f1a[0] !== 8'h02 || f2a[0] !== 8'h03) begin failures++; $display("FAIL refetch got=pc%h a=%h/%h exp=pc02 a=02/03", pcv[0], f1a[0], f2a[0]); end
        checks++; if (opc[0] !== 8'h11 || opr[0] !== 8'h22 || vld[0] !== 1'b1 || err[0] !== 1'b1) begin failures++; $display("FAIL refetch_instr got=%h/%h v%b e%b exp=11/22 v1 e1", opc[0], opr[0], vld[0], err[0]); end
    endtask

    task automatic test_multi_trigger();
        do_reset();
        step(T_UPD, 1'b0);
        step(T_F1 | T_D1, 1'b0);
        checks++; if (err[0] !== 1'b1 || vld[0] !== 1'b0 || pcv[0] !== 8'h00) begin failures++; $display("FAIL multi_err got=e%b v%b pc=%h exp=e1 v0 pc=00", err[0], vld[0], pcv[0]); end
        step(T_UPD, 1'b0);
        step(T_F1, 1'b0);
        step(T_D1, 1'b0);
        checks++; if (opc[0] !== 8'h3A || err[0] !== 1'b1) begin failures++; $display("FAIL multi_recover got=%h e%b exp=3a e1", opc[0], err[0]); end
        do_reset();
        checks++; if (pcv[0] !== 8'h00 || opc[0] !== 8'h00 || opr[0] !== 8'h00 || vld[0] !== 1'b0 || err[0] !== 1'b0) begin failures++; $display("FAIL midreset got=pc%h %h/%h v%b e%b exp=pc00 00/00 v0 e0", pcv[0], opc[0], opr[0], vld[0], err[0]); end
        run_instr();
        checks++; if (opc[0] !== 8'h3A || opr[0] !== 8'h7F || vld[0] !== 1'b1 || err[0] !== 1'b0) begin failures++; $display("FAIL after_reset got=%h/%h v%b e%b exp=3a/7f v1 e0", opc[0], opr[0], vld[0], err[0]); end
    endtask

    task automatic test_jump();
`ifdef INSTR_FETCH_JUMP_EN
        exp_pc = 8'h40; exp_a1 = 8'h40; exp_op = 8'hC3;
`else
        exp_pc = 8'h02; exp_a1 = 8'h02; exp_op = 8'h11;
`endif
        do_reset();
        run_instr();
        jump_req = 1'b1;
        jump_target = 8'h40;
        step(T_UPD, 1'b0);
        jump_req = 1'b0;
        checks++; if (pcv[0] !== exp_pc) begin failures++; $display("FAIL jump_pc got=%h exp=%h", pcv[0], exp_pc); end
        step(T_F1, 1'b0);
        for (int k = 0; k < 3; k++) f1a[k] = last_addr[k];
        step(T_D1, 1'b0);
        step(T_F2, 1'b1);
        for (int k = 0; k < 3; k++) f2a[k] = last_addr[k];
        step(T_D2, 1'b1);
        checks++; if (f1a[0] !== exp_a1 || f2a[0] !== exp_a1 + 8'h01) begin failures++; $display("FAIL jump_addr got=%h/%h exp=%h/%h", f1a[0], f2a[0], exp_a1, exp_a1 + 8'h01); end
        checks++; if (opc[0] !== exp_op) begin failures++; $display("FAIL jump_opcode got=%h exp=%h", opc[0], exp_op); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        n_reset = 1'b1;
        {upd, f1, d1, f2, d2} = T_NONE;
        mux = 1'b0;
        jump_req = 1'b0;
        jump_target = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h00] = 8'h3A; mem[8'h01] = 8'h7F;
        mem[8'h02] = 8'h11; mem[8'h03] = 8'h22;
        mem[8'h40] = 8'hC3; mem[8'h41] = 8'hD4;
        mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2;

        test_reset();
        test_first_instr();
        test_second_instr();
        test_pc_wrap();
        test_wrong_order();
        test_multi_trigger();
        test_jump();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
